// File: rtl/game_pkg.sv
// Shared game constants: scan codes, direction encodings and the direction FSM state type.
package game_pkg;

    localparam logic [8:0] KEY_A = 9'h01C;
    localparam logic [8:0] KEY_D = 9'h023;
    localparam logic [8:0] KEY_P = 9'h04D;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_R    = 2'b01;
    localparam logic [1:0] DIR_L    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } dir_state_e;

    function automatic logic [1:0] state_dir(input dir_state_e s);
        case (s)
            ST_LEFT:  state_dir = DIR_L;
            ST_RIGHT: state_dir = DIR_R;
            default:  state_dir = DIR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// Auto-repeat down-counter. Load sets the initial delay, expiry reloads the repeat
// interval, and clear parks the counter at zero.
module repeat_timer #(
    parameter int CNT_W        = 8,
    parameter int DELAY_TICKS  = 8,
    parameter int REPEAT_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic load_i,
    input  logic tick_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over load, and load wins over tick. Zero is sticky, so the count never wraps.
    always_comb begin
        cnt_d    = cnt_q;
        expire_o = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(DELAY_TICKS);
        end else if (tick_i && (cnt_q != '0)) begin
            if (cnt_q == CNT_W'(1)) begin
                expire_o = 1'b1;
                cnt_d    = CNT_W'(REPEAT_TICKS);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/key_move_ctrl.sv
// Turns PS/2 key events into a held-direction level and rate-limited move pulses,
// with last-pressed-wins conflict resolution and a pause toggle.
module key_move_ctrl
    import game_pkg::*;
#(
    parameter logic [8:0] KEY_LEFT     = KEY_A,
    parameter logic [8:0] KEY_RIGHT    = KEY_D,
    parameter logic [8:0] KEY_PAUSE    = KEY_P,
    parameter int         DELAY_TICKS  = 8,
    parameter int         REPEAT_TICKS = 2,
    parameter int         CNT_W        = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] key_down,
    input  logic [8:0]   last_change,
    input  logic         key_valid,
    input  logic         tick,
    output logic [1:0]   key,
    output logic         move_pulse,
    output logic         move_dir,
    output logic         paused
);

    dir_state_e state_q, state_d;
    logic       paused_q, paused_d;
    logic [1:0] key_q, key_d;
    logic       pulse_q, pulse_d;
    logic       dir_q, dir_d;

    logic press;
    logic active;
    logic entry;
    logic expire;

    assign press = key_down[last_change];

    always_comb begin
        state_d = state_q;
        if (key_valid) begin
            if (last_change == KEY_LEFT) begin
                if (press) begin
                    state_d = ST_LEFT;
                end else if (state_q == ST_LEFT) begin
                    state_d = key_down[KEY_RIGHT] ? ST_RIGHT : ST_IDLE;
                end
            end else if (last_change == KEY_RIGHT) begin
                if (press) begin
                    state_d = ST_RIGHT;
                end else if (state_q == ST_RIGHT) begin
                    state_d = key_down[KEY_LEFT] ? ST_LEFT : ST_IDLE;
                end
            end
        end
    end

    assign paused_d = paused_q ^ (key_valid && (last_change == KEY_PAUSE) && press);

    // Entry covers a fresh direction as well as leaving pause while a direction is held.
    assign active = (state_d != ST_IDLE) && !paused_d;
    assign entry  = active && ((state_d != state_q) || paused_q);

    repeat_timer #(
        .CNT_W        (CNT_W),
        .DELAY_TICKS  (DELAY_TICKS),
        .REPEAT_TICKS (REPEAT_TICKS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!active),
        .load_i   (entry),
        .tick_i   (tick && !key_valid),
        .expire_o (expire)
    );

    assign pulse_d = (entry || expire) && !pulse_q;
    assign dir_d   = pulse_d ? (state_d == ST_RIGHT) : dir_q;
    assign key_d   = paused_d ? DIR_NONE : state_dir(state_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            paused_q <= 1'b0;
            key_q    <= DIR_NONE;
            pulse_q  <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            paused_q <= paused_d;
            key_q    <= key_d;
            pulse_q  <= pulse_d;
            dir_q    <= dir_d;
        end
    end

    assign key        = key_q;
    assign move_pulse = pulse_q;
    assign move_dir   = dir_q;
    assign paused     = paused_q;

endmodule

// File: tb/tb_key_move_ctrl.sv
// Directed bench for key_move_ctrl: direction conflicts, auto-repeat timing, pause and reset.
module tb_key_move_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] key_down = '0;
    logic [8:0]   last_change = '0;
    logic         key_valid = 1'b0;
    logic         tick = 1'b0;
    logic [1:0]   key;
    logic         move_pulse;
    logic         move_dir;
    logic         paused;

    int checks = 0;
    int errors = 0;
    int np;

    localparam logic [8:0] A = 9'h01C;
    localparam logic [8:0] D = 9'h023;
    localparam logic [8:0] P = 9'h04D;
    localparam logic [8:0] X = 9'h029;

    key_move_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_down    (key_down),
        .last_change (last_change),
        .key_valid   (key_valid),
        .tick        (tick),
        .key         (key),
        .move_pulse  (move_pulse),
        .move_dir    (move_dir),
        .paused      (paused)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic ev(input logic [8:0] code, input logic down, input logic tk);
        key_down[code] = down;
        last_change    = code;
        key_valid      = 1'b1;
        tick           = tk;
        step();
        key_valid = 1'b0;
        tick      = 1'b0;
    endtask

    // Each tick is followed by an idle cycle; pulses are counted over every cycle.
    task automatic ticks(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            pulses += int'(move_pulse);
            step();
            pulses += int'(move_pulse);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step();
        step();
        rst = 1'b0;
        chk("reset_key", int'(key), 0);
        chk("reset_pulse", int'(move_pulse), 0);
        chk("reset_dir", int'(move_dir), 0);
        chk("reset_paused", int'(paused), 0);

        // Press A: immediate left pulse, first repeat after 8 ticks, then every 2
        ev(A, 1'b1, 1'b0);
        chk("a_key", int'(key), 2);
        chk("a_pulse", int'(move_pulse), 1);
        chk("a_dir", int'(move_dir), 0);
        step();
        chk("a_pulse_once", int'(move_pulse), 0);
        ticks(7, np);
        chk("a_delay_quiet", np, 0);
        ticks(1, np);
        chk("a_first_repeat", np, 1);
        ticks(1, np);
        chk("a_rep_gap", np, 0);
        ticks(1, np);
        chk("a_rep2", np, 1);
        ticks(4, np);
        chk("a_rep_rate", np, 2);

        // Hold A, press D, release D
        ev(D, 1'b1, 1'b0);
        chk("d_over_a_key", int'(key), 1);
        chk("d_over_a_pulse", int'(move_pulse), 1);
        chk("d_over_a_dir", int'(move_dir), 1);
        step();
        ev(D, 1'b0, 1'b0);
        chk("d_rel_key", int'(key), 2);
        chk("d_rel_pulse", int'(move_pulse), 1);
        chk("d_rel_dir", int'(move_dir), 0);
        step();

        // Release A with D not held
        ev(A, 1'b0, 1'b0);
        chk("a_rel_key", int'(key), 0);
        chk("a_rel_pulse", int'(move_pulse), 0);
        ticks(20, np);
        chk("idle_no_pulses", np, 0);

        // Hold D, pause, unpause
        ev(D, 1'b1, 1'b0);
        chk("d_key", int'(key), 1);
        chk("d_pulse", int'(move_pulse), 1);
        step();
        ev(P, 1'b1, 1'b0);
        chk("pause_flag", int'(paused), 1);
        chk("pause_key", int'(key), 0);
        chk("pause_pulse", int'(move_pulse), 0);
        ticks(20, np);
        chk("pause_no_pulses", np, 0);
        ev(P, 1'b0, 1'b0);
        chk("pause_release_ignored", int'(paused), 1);
        step();
        ev(P, 1'b1, 1'b0);
        chk("unpause_flag", int'(paused), 0);
        chk("unpause_key", int'(key), 1);
        chk("unpause_pulse", int'(move_pulse), 1);
        chk("unpause_dir", int'(move_dir), 1);
        step();
        ticks(7, np);
        chk("unpause_delay_quiet", np, 0);
        ticks(1, np);
        chk("unpause_repeat", np, 1);

        // Event and tick in the same cycle: the tick must be dropped
        ev(D, 1'b0, 1'b0);
        chk("d_rel_idle_key", int'(key), 0);
        step();
        ev(D, 1'b1, 1'b1);
        chk("same_cycle_pulse", int'(move_pulse), 1);
        step();
        ticks(7, np);
        chk("same_cycle_7_ticks", np, 0);
        ticks(1, np);
        chk("same_cycle_8th_tick", np, 1);

        // Reset mid-repeat while paused
        ev(P, 1'b1, 1'b0);
        chk("pre_rst_paused", int'(paused), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_key", int'(key), 0);
        chk("rst_paused", int'(paused), 0);
        chk("rst_pulse", int'(move_pulse), 0);
        chk("rst_dir", int'(move_dir), 0);
        ticks(20, np);
        chk("rst_no_pulses", np, 0);

        // Unrelated scan code
        ev(X, 1'b1, 1'b0);
        chk("other_key", int'(key), 0);
        chk("other_pulse", int'(move_pulse), 0);
        chk("other_paused", int'(paused), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
